// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the byte-serial CRC-16/0x1021 engine.
package crc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          CRC16_W    = 16;
  localparam int          NIBBLE_W   = 4;

  // IDLE: waiting for a byte (high nibble folded on accept)
  // LO:   folding the latched low nibble
  // DONE: presenting the finished CRC downstream
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    DONE = 2'd2
  } crc16_state_e;

endpackage

// File: rtl/crc16_1021.sv
// Combinational CRC-16 step: folds one nibble, MSB first, into a running CRC
// using the non-reflected 0x1021 polynomial.
module crc16_1021
  import crc_pkg::*;
(
  input  logic [NIBBLE_W-1:0] data_i,
  input  logic [CRC16_W-1:0]  crc_i,
  output logic [CRC16_W-1:0]  crc_o
);

  // Four serial shift/XOR steps unrolled, data bit 3 first.
  always_comb begin
    logic [CRC16_W-1:0] c;
    logic               fb;
    c = crc_i;
    for (int i = NIBBLE_W - 1; i >= 0; i--) begin
      fb = c[CRC16_W-1] ^ data_i[i];
      c  = {c[CRC16_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_byte_engine.sv
// Byte-stream CRC-16 accumulator. Each accepted byte is folded in two cycles
// (high nibble on accept, low nibble in LO); the final CRC is offered in DONE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: valid_i/ready_o, where ready_o depends only on state
// and clr_i. Output side: crc_valid_o/crc_ready_i, where crc_valid_o is a pure
// state decode and crc_o is held stable until the transfer completes.
module crc16_byte_engine
  import crc_pkg::*;
#(
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic [7:0]  data_i,
  input  logic        sof_i,
  input  logic        eof_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] crc_o,
  output logic        crc_valid_o,
  input  logic        crc_ready_i,
  output logic        busy_o
);

  crc16_state_e          state_q, state_d;
  logic [CRC16_W-1:0]    crc_q, crc_d;
  logic [NIBBLE_W-1:0]   lo_q, lo_d;
  logic                  last_q, last_d;

  logic                  accept;
  logic [NIBBLE_W-1:0]   step_data;
  logic [CRC16_W-1:0]    step_seed;
  logic [CRC16_W-1:0]    step_out;

  // Single shared step: high nibble from the bus in IDLE, latched low nibble in LO.
  always_comb begin
    step_data = (state_q == LO) ? lo_q : data_i[7:4];
    step_seed = (state_q == IDLE && sof_i) ? INIT : crc_q;
  end

  crc16_1021 u_step (
    .data_i (step_data),
    .crc_i  (step_seed),
    .crc_o  (step_out)
  );

  // Output decodes; nothing here looks at valid_i or crc_ready_i.
  always_comb begin
    ready_o     = (state_q == IDLE) & ~clr_i;
    crc_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    crc_o       = crc_q ^ XOROUT;
    accept      = valid_i & ready_o;
  end

  // Next-state logic; clr_i overrides every state and any concurrent byte.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    lo_d    = lo_q;
    last_d  = last_q;
    if (clr_i) begin
      state_d = IDLE;
      crc_d   = INIT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            crc_d   = step_out;
            lo_d    = data_i[3:0];
            last_d  = eof_i;
            state_d = LO;
          end
        end
        LO: begin
          crc_d   = step_out;
          state_d = last_q ? DONE : IDLE;
        end
        DONE: begin
          if (crc_ready_i) begin
            crc_d   = INIT;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          crc_d   = INIT;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      lo_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_crc16_byte_engine.sv
// Bench for crc16_byte_engine: instance 0 uses INIT=0, instance 1 uses INIT=FFFF.
// Drivers push expected CRCs; a per-instance monitor pops on each result transfer.
module tb_crc16_byte_engine;

  logic        clk;
  logic        rst_n;
  logic        clr       [2];
  logic [7:0]  data      [2];
  logic        sof       [2];
  logic        eof       [2];
  logic        valid     [2];
  logic        ready     [2];
  logic [15:0] crc       [2];
  logic        crc_valid [2];
  logic        crc_ready [2];
  logic        busy      [2];

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_hs_cyc [2];
  int first_acc;
  int acc_cnt;
  logic r;

  logic [7:0] frame [9];

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc16_byte_engine #(.INIT(16'h0000), .XOROUT(16'h0000)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr[0]), .data_i(data[0]),
    .sof_i(sof[0]), .eof_i(eof[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .crc_o(crc[0]), .crc_valid_o(crc_valid[0]), .crc_ready_i(crc_ready[0]),
    .busy_o(busy[0])
  );

  crc16_byte_engine #(.INIT(16'hFFFF), .XOROUT(16'h0000)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr[1]), .data_i(data[1]),
    .sof_i(sof[1]), .eof_i(eof[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .crc_o(crc[1]), .crc_valid_o(crc_valid[1]), .crc_ready_i(crc_ready[1]),
    .busy_o(busy[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int d, input logic [15:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Scoreboard monitor: compares on every result transfer seen at negedge.
  task automatic monitor(input int d);
    logic [15:0] e;
    if (crc_valid[d] && crc_ready[d]) begin
      last_hs_cyc[d] = cyc + 1;
      if (q_size(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result dut%0d: got %h expected none", d, crc[d]);
      end else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("result_dut%0d", d), crc[d], e);
      end
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  // Driver: call at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input int d, input logic [7:0] b, input logic s, input logic e);
    int n = 0;
    data[d] = b; sof[d] = s; eof[d] = e; valid[d] = 1'b1;
    #1;
    while (!ready[d] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d: ready stayed 0 expected 1", d);
    end
    @(posedge clk);
    @(negedge clk);
    last_acc_cyc = cyc;
    valid[d] = 1'b0; sof[d] = 1'b0; eof[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input logic use_sof);
    for (int i = 0; i < 9; i++) send_byte(d, frame[i], use_sof && (i == 0), i == 8);
  endtask

  task automatic wait_empty(input int d);
    int n = 0;
    while (q_size(d) > 0 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (q_size(d) > 0) begin
      errors++;
      $display("FAIL result_timeout dut%0d: pending=%0d expected 0", d, q_size(d));
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 0; data[d] = 0; sof[d] = 0; eof[d] = 0; valid[d] = 0; crc_ready[d] = 1;
      last_hs_cyc[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 16'(ready[d]), 16'd1);
      chk($sformatf("rst_valid%0d", d), 16'(crc_valid[d]), 16'd0);
      chk($sformatf("rst_busy%0d", d), 16'(busy[d]), 16'd0);
    end
    @(negedge clk);

    // INIT=0 over "123456789", with latency checks
    push_exp(0, 16'h31C3);
    send_byte(0, frame[0], 1'b1, 1'b0);
    first_acc = last_acc_cyc;
    for (int i = 1; i < 9; i++) send_byte(0, frame[i], 1'b0, i == 8);
    chk("lat_lo_valid", 16'(crc_valid[0]), 16'd0);
    @(negedge clk);
    chk("lat_done_valid", 16'(crc_valid[0]), 16'd1);
    wait_empty(0);
    chk("first_acc_to_result", 16'(last_hs_cyc[0] - first_acc), 16'd18);

    // INIT=FFFF, result held under back-pressure
    push_exp(1, 16'h29B1);
    crc_ready[1] = 1'b0;
    send_frame(1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 16'(crc_valid[1]), 16'd1);
      chk("hold_crc", crc[1], 16'h29B1);
      chk("hold_ready", 16'(ready[1]), 16'd0);
      @(negedge clk);
    end
    crc_ready[1] = 1'b1;
    wait_empty(1);

    // Single-byte frames back-to-back on INIT=0
    push_exp(0, 16'h1021); push_exp(0, 16'h58E5); push_exp(0, 16'h0000);
    begin
      logic [7:0] sb [3];
      sb[0] = 8'h01; sb[1] = 8'h41; sb[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
        send_byte(0, sb[i], 1'b1, 1'b1);
        @(negedge clk);
        chk("single_done_ready", 16'(ready[0]), 16'd0);
        @(negedge clk);
        chk("single_ready_back", 16'(ready[0]), 16'd1);
      end
    end
    wait_empty(0);

    // Abort with clr_i in LO, byte presented with clr_i is refused
    for (int i = 0; i < 4; i++) send_byte(1, frame[i], i == 0, 1'b0);
    clr[1] = 1'b1; valid[1] = 1'b1; data[1] = 8'h35; eof[1] = 1'b1;
    #1;
    chk("clr_ready", 16'(ready[1]), 16'd0);
    @(negedge clk);
    clr[1] = 1'b0; valid[1] = 1'b0; eof[1] = 1'b0;
    #1;
    chk("clr_busy", 16'(busy[1]), 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("clr_no_valid", 16'(crc_valid[1]), 16'd0);
    end
    push_exp(1, 16'h29B1);
    send_frame(1, 1'b1);
    wait_empty(1);

    // valid_i held high over a 3-byte frame
    begin
      logic [7:0] vb [3];
      int idx;
      vb[0] = 8'h00; vb[1] = 8'h00; vb[2] = 8'h41;
      push_exp(0, 16'h58E5);
      idx = 0; acc_cnt = 0;
      data[0] = vb[0]; sof[0] = 1'b1; eof[0] = 1'b0; valid[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        #1;
        r = ready[0];
        chk($sformatf("stream_ready_%0d", k), 16'(r), (k % 2 == 0) ? 16'd1 : 16'd0);
        @(posedge clk);
        if (r && valid[0]) begin idx++; acc_cnt++; end
        @(negedge clk);
        if (idx < 3) begin
          data[0] = vb[idx]; sof[0] = 1'b0; eof[0] = (idx == 2);
        end else begin
          valid[0] = 1'b0; eof[0] = 1'b0;
        end
      end
      chk("stream_accepts", 16'(acc_cnt), 16'd3);
      wait_empty(0);
    end

    // Asynchronous reset while in DONE, then seed check without sof_i
    crc_ready[1] = 1'b0;
    send_byte(1, 8'h31, 1'b1, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 16'(crc_valid[1]), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 16'(crc_valid[1]), 16'd0);
    chk("async_rst_busy", 16'(busy[1]), 16'd0);
    chk("async_rst_crc", crc[1], 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    crc_ready[1] = 1'b1;
    push_exp(1, 16'h29B1);
    send_frame(1, 1'b0);
    wait_empty(1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
